// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Purpose  : Receive buffer between the serial rx character assembler and
//            the console keyboard IOT logic. Captures one character per rx
//            flag assertion, acknowledges it with a one-cycle clear pulse and
//            queues it in a DEPTH-entry first-word-fall-through FIFO. A
//            sticky overrun bit records characters dropped while full.
// Revision : 1.0  initial release
// ============================================================================
module rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 rx_flag,
  input  logic [0:7]           rx_char,
  output logic                 rx_clear_flag,
  input  logic                 rd,
  output logic [0:7]           rd_data,
  output logic                 not_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam logic [ADDR_BITS:0]   c_full_count = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   c_zero_count = '0;
  localparam logic [ADDR_BITS-1:0] c_ptr_one    = (ADDR_BITS)'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  not_empty_q, not_empty_d;
  logic                  clear_flag_q, clear_flag_d;
  logic [0:7]            rd_data_q, rd_data_d;
  logic [0:7]            mem_q [DEPTH];

  logic                  capture;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  discard;
  logic                  mem_we;

  // Capture FSM: one write attempt per rising rx_flag, then ack, then wait
  // for rx to drop its flag so a slow flag drop never causes a re-capture.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_flag) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:       state_d = WAIT_DROP;
      WAIT_DROP: if (!rx_flag) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // FIFO bookkeeping: a full FIFO still accepts a character when the head
  // is popped in the same cycle; a pop on an empty FIFO is ignored.
  always_comb begin
    full      = (count_q == c_full_count);
    pop       = rd && (count_q != c_zero_count);
    push      = capture && (!full || rd);
    discard   = capture && !push;

    wr_ptr_d  = push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting wins over clearing when both happen together.
    if (discard) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    not_empty_d  = (count_d != c_zero_count);
    clear_flag_d = (state_d == ACK);

    // Registered head: if the new head is the slot being written this cycle
    // it comes straight from rx_char, otherwise from storage. When the FIFO
    // becomes empty the old value is held so it never picks up an unwritten
    // entry.
    if (count_d == c_zero_count) begin
      rd_data_d = rd_data_q;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = rx_char;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end

    mem_we = push && !clear;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overrun_d    = 1'b0;
      not_empty_d  = 1'b0;
      clear_flag_d = 1'b0;
      rd_data_d    = '0;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      not_empty_q  <= 1'b0;
      clear_flag_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      not_empty_q  <= not_empty_d;
      clear_flag_q <= clear_flag_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Character storage; contents are only read once written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= rx_char;
    end
  end

  assign rx_clear_flag = clear_flag_q;
  assign rd_data       = rd_data_q;
  assign not_empty     = not_empty_q;
  assign count         = count_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_fifo
// Purpose  : Self-checking bench for rx_fifo. A driver issues characters and
//            pops; a negedge monitor keeps a queue-based reference of the
//            FIFO contents and compares every DUT output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_fifo;

  localparam int DEPTH     = 16;
  localparam int ADDR_BITS = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic               rx_flag;
  logic [0:7]         rx_char;
  logic               rx_clear_flag;
  logic               rd;
  logic [0:7]         rd_data;
  logic               not_empty;
  logic [ADDR_BITS:0] count;
  logic               overrun;
  logic               clr_overrun;

  rx_fifo #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .rx_flag       (rx_flag),
    .rx_char       (rx_char),
    .rx_clear_flag (rx_clear_flag),
    .rd            (rd),
    .rd_data       (rd_data),
    .not_empty     (not_empty),
    .count         (count),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs and the "a character is being issued this cycle" marker.
  bit cap      = 1'b0;
  int rd_prob  = 0;
  int clr_prob = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  bit         m_ovr      = 1'b0;
  bit         prev_cap   = 1'b0;
  bit         was_clear  = 1'b0;
  int         ack_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare outputs against the model, then advance the
  // model by what the upcoming clock edge does.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_ack",      32'(rx_clear_flag), 32'd0);
      check("reset_count",    32'(count),         32'd0);
      check("reset_notempty", 32'(not_empty),     32'd0);
      check("reset_overrun",  32'(overrun),       32'd0);
      check("reset_rd_data",  32'(rd_data),       32'd0);
      m_q.delete();
      m_ovr     = 1'b0;
      prev_cap  = 1'b0;
      was_clear = 1'b0;
    end else begin
      bit pop_now;
      bit accept;
      check("ack",       32'(rx_clear_flag), 32'(prev_cap));
      check("count",     32'(count),         32'(m_q.size()));
      check("not_empty", 32'(not_empty),     32'(m_q.size() != 0));
      check("overrun",   32'(overrun),       32'(m_ovr));
      if (m_q.size() != 0) check("rd_data", 32'(rd_data), 32'(m_q[0]));
      if (was_clear)       check("clear_rd_data", 32'(rd_data), 32'd0);
      if (rx_clear_flag) ack_seen++;
      was_clear = 1'b0;
      if (clear) begin
        m_q.delete();
        m_ovr     = 1'b0;
        prev_cap  = 1'b0;
        was_clear = 1'b1;
      end else begin
        pop_now = rd && (m_q.size() != 0);
        accept  = cap && ((m_q.size() < DEPTH) || rd);
        if (pop_now) void'(m_q.pop_front());
        if (accept)  m_q.push_back(8'(rx_char));
        if (cap && !accept) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        prev_cap = cap;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cap         = 1'b0;
    rd          = ($urandom_range(0, 99) < rd_prob);
    clr_overrun = ($urandom_range(0, 99) < clr_prob);
  endtask

  // Present one character; rx_flag is held for 2+extra cycles and dropped
  // while the capture logic is waiting, so exactly one capture is expected.
  task automatic send(input logic [7:0] c, input int extra, input bit rd_cap);
    tick();
    rx_char = c;
    rx_flag = 1'b1;
    cap     = 1'b1;
    if (rd_cap) rd = 1'b1;
    tick();
    tick();
    repeat (extra) tick();
    rx_flag = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_prob = 100;
    repeat (n) tick();
    rd_prob = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack0;
    reset = 1'b1; clear = 1'b0; rx_flag = 1'b0; rx_char = '0;
    rd = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single character, then pop it.
    send(8'o200, 0, 1'b0);
    tick();
    check("single_count", 32'(count), 32'd1);
    check("single_data",  32'(rd_data), 32'o200);
    pop_n(1);
    check("single_empty", 32'(not_empty), 32'd0);

    // Three characters in order.
    send(8'o200, 0, 1'b0);
    send(8'o300, 1, 1'b0);
    send(8'o017, 0, 1'b0);
    pop_n(3);
    check("three_overrun", 32'(overrun), 32'd0);

    // Seventeen characters into a sixteen-entry FIFO.
    ack0 = ack_seen;
    for (int i = 1; i <= 17; i++) send(8'(i), 0, 1'b0);
    tick();
    check("fill_count",   32'(count), 32'd16);
    check("fill_overrun", 32'(overrun), 32'd1);
    check("fill_acks",    32'(ack_seen - ack0), 32'd17);
    pop_n(16);

    // Refill, clear overrun, then capture while popping on a full FIFO.
    tick(); clr_overrun = 1'b1; tick();
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0, 1'b0);
    send(8'h99, 0, 1'b1);
    tick();
    check("fullrd_count",   32'(count), 32'd16);
    check("fullrd_overrun", 32'(overrun), 32'd0);
    pop_n(16);

    // Long rx_flag hold: one write, one acknowledge.
    ack0 = ack_seen;
    send(8'h5a, 3, 1'b0);
    tick(); tick();
    check("hold_acks",  32'(ack_seen - ack0), 32'd1);
    check("hold_count", 32'(count), 32'd1);
    pop_n(1);

    // Reads on an empty FIFO.
    pop_n(4);
    check("empty_rd_count", 32'(count), 32'd0);

    // Asynchronous reset in the acknowledge cycle with three stored.
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 0, 1'b0);
    tick();
    rx_char = 8'h77; rx_flag = 1'b1; cap = 1'b1;
    tick();
    reset = 1'b1; rx_flag = 1'b0;
    #1;
    check("async_ack",      32'(rx_clear_flag), 32'd0);
    check("async_count",    32'(count),         32'd0);
    check("async_notempty", 32'(not_empty),     32'd0);
    check("async_overrun",  32'(overrun),       32'd0);
    check("async_rd_data",  32'(rd_data),       32'd0);
    tick();
    reset = 1'b0;

    // Synchronous clear in the acknowledge cycle.
    send(8'h21, 0, 1'b0);
    tick();
    rx_char = 8'h22; rx_flag = 1'b1; cap = 1'b1;
    tick();
    clear = 1'b1; rx_flag = 1'b0;
    tick();
    clear = 1'b0;
    tick();

    // Randomized traffic with pops, overrun clears and occasional clears.
    rd_prob  = 40;
    clr_prob = 5;
    for (int n = 0; n < 300; n++) begin
      send(8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        tick(); clear = 1'b1; tick(); clear = 1'b0;
      end
    end
    rd_prob  = 0;
    clr_prob = 0;
    pop_n(DEPTH + 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
